// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS execute path: ALU op codes,
// forward-select encodings, default widths and a muldiv op helper.
package mips_pkg;

    localparam int DEF_WIDTH         = 32;
    localparam int DEF_MULDIV_CYCLES = 32;

    typedef enum logic [3:0] {
        OP_ADD  = 4'd0,
        OP_SUB  = 4'd1,
        OP_AND  = 4'd2,
        OP_OR   = 4'd3,
        OP_XOR  = 4'd4,
        OP_NOR  = 4'd5,
        OP_SLT  = 4'd6,
        OP_SLTU = 4'd7,
        OP_SLL  = 4'd8,
        OP_SRL  = 4'd9,
        OP_SRA  = 4'd10,
        OP_LUI  = 4'd11,
        OP_MULT = 4'd12,
        OP_DIVU = 4'd13,
        OP_MFHI = 4'd14,
        OP_MFLO = 4'd15
    } alu_op_e;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

    function automatic logic is_muldiv(input logic [3:0] op);
        return (op == OP_MULT) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative MULT (signed, shift-add with sign fix-up) / DIVU (restoring)
// engine owning HI/LO; one bit per BUSY cycle, so CYCLES should equal WIDTH.
// Ports: clk, rst (sync, active-high), hold (freeze everything), start, op
// (0=MULT, 1=DIVU), a, b in; busy, done, hi, lo out.
module muldiv_unit
    import mips_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int CYCLES = DEF_MULDIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             start,
    input  logic             op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (CYCLES > 1) ? $clog2(CYCLES) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         state;
    logic [CW-1:0]      cnt;
    logic               is_div;
    logic               neg;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_nxt;
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH:0]     trial;

    function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
        return v[WIDTH-1] ? -v : v;
    endfunction

    // Multiply: acc = {partial, multiplier}, add-then-shift-right.
    // Divide:   acc = {remainder, dividend/quotient}, shift-left-then-trial.
    // A zero divisor always takes the "subtract" branch, which yields
    // an all-ones quotient and shifts the dividend into the remainder.
    always_comb begin
        add_sum = {1'b0, acc[2*WIDTH-1:WIDTH]}
                + (acc[0] ? {1'b0, opnd} : '0);
        trial   = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opnd};
        acc_nxt = acc;
        if (is_div) begin
            if (!trial[WIDTH] || (opnd == '0)) begin
                acc_nxt = {trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
            end else begin
                acc_nxt = {acc[2*WIDTH-2:0], 1'b0};
            end
        end else begin
            acc_nxt = {add_sum, acc[WIDTH-1:1]};
        end
        prod = neg ? -acc_nxt : acc_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            is_div <= 1'b0;
            neg    <= 1'b0;
            opnd   <= '0;
            acc    <= '0;
            hi     <= '0;
            lo     <= '0;
        end else if (!hold) begin
            unique case (state)
                S_IDLE: begin
                    if (start) begin
                        state  <= S_BUSY;
                        cnt    <= CW'(CYCLES - 1);
                        is_div <= op;
                        if (op) begin
                            opnd <= b;
                            acc  <= {{WIDTH{1'b0}}, a};
                            neg  <= 1'b0;
                        end else begin
                            opnd <= mag(a);
                            acc  <= {{WIDTH{1'b0}}, mag(b)};
                            neg  <= a[WIDTH-1] ^ b[WIDTH-1];
                        end
                    end
                end
                S_BUSY: begin
                    acc <= acc_nxt;
                    if (cnt == '0) begin
                        state <= S_DONE;
                        if (is_div) begin
                            hi <= acc_nxt[2*WIDTH-1:WIDTH];
                            lo <= acc_nxt[WIDTH-1:0];
                        end else begin
                            hi <= prod[2*WIDTH-1:WIDTH];
                            lo <= prod[WIDTH-1:0];
                        end
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = (state == S_BUSY);
    assign done = (state == S_DONE);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU/shift/LUI, muldiv sequencing and
// the EX/MEM pipeline register. Ports: ID/EX operands+controls, forward
// selects and data, mem_stall in; ex_stall and EX/MEM register fields out.
module ex_stage
    import mips_pkg::*;
#(
    parameter int WIDTH         = DEF_WIDTH,
    parameter int MULDIV_CYCLES = DEF_MULDIV_CYCLES
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_ex_valid,
    input  logic [WIDTH-1:0] id_ex_rs_data,
    input  logic [WIDTH-1:0] id_ex_rt_data,
    input  logic [WIDTH-1:0] id_ex_imm,
    input  logic [3:0]       id_ex_alu_op,
    input  logic             id_ex_alu_src,
    input  logic             id_ex_regwrite,
    input  logic             id_ex_memread,
    input  logic             id_ex_memwrite,
    input  logic             id_ex_memtoreg,
    input  logic [4:0]       id_ex_dst,
    input  logic [1:0]       forward_a,
    input  logic [1:0]       forward_b,
    input  logic [WIDTH-1:0] ex_mem_fwd_data,
    input  logic [WIDTH-1:0] mem_wb_fwd_data,
    input  logic             mem_stall,
    output logic             ex_stall,
    output logic             ex_mem_valid,
    output logic [WIDTH-1:0] ex_mem_alu_result,
    output logic [WIDTH-1:0] ex_mem_store_data,
    output logic [4:0]       ex_mem_rd,
    output logic             ex_mem_regwrite,
    output logic             ex_mem_memread,
    output logic             ex_mem_memwrite,
    output logic             ex_mem_memtoreg
);

    alu_op_e          op;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opbf;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] lui_val;
    logic [4:0]       shamt;
    logic             md_op;
    logic             md_busy;
    logic             md_done;
    logic [WIDTH-1:0] md_hi;
    logic [WIDTH-1:0] md_lo;

    assign op      = alu_op_e'(id_ex_alu_op);
    assign shamt   = id_ex_imm[10:6];
    assign lui_val = {{(WIDTH-16){1'b0}}, id_ex_imm[15:0]} << 16;
    assign md_op   = id_ex_valid && is_muldiv(id_ex_alu_op);

    always_comb begin
        unique case (forward_a)
            FWD_EXMEM: opa = ex_mem_fwd_data;
            FWD_MEMWB: opa = mem_wb_fwd_data;
            default:   opa = id_ex_rs_data;
        endcase
    end

    always_comb begin
        unique case (forward_b)
            FWD_EXMEM: opbf = ex_mem_fwd_data;
            FWD_MEMWB: opbf = mem_wb_fwd_data;
            default:   opbf = id_ex_rt_data;
        endcase
    end

    assign opb = id_ex_alu_src ? id_ex_imm : opbf;

    always_comb begin
        alu_res = '0;
        unique case (op)
            OP_ADD:  alu_res = opa + opb;
            OP_SUB:  alu_res = opa - opb;
            OP_AND:  alu_res = opa & opb;
            OP_OR:   alu_res = opa | opb;
            OP_XOR:  alu_res = opa ^ opb;
            OP_NOR:  alu_res = ~(opa | opb);
            OP_SLT:  alu_res = WIDTH'($signed(opa) < $signed(opb));
            OP_SLTU: alu_res = WIDTH'(opa < opb);
            OP_SLL:  alu_res = opbf << shamt;
            OP_SRL:  alu_res = opbf >> shamt;
            OP_SRA:  alu_res = $signed(opbf) >>> shamt;
            OP_LUI:  alu_res = lui_val;
            OP_MULT: alu_res = '0;
            OP_DIVU: alu_res = '0;
            OP_MFHI: alu_res = md_hi;
            OP_MFLO: alu_res = md_lo;
        endcase
    end

    muldiv_unit #(
        .WIDTH  (WIDTH),
        .CYCLES (MULDIV_CYCLES)
    ) u_muldiv (
        .clk   (clk),
        .rst   (rst),
        .hold  (mem_stall),
        .start (md_op),
        .op    (op == OP_DIVU),
        .a     (opa),
        .b     (opbf),
        .busy  (md_busy),
        .done  (md_done),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    // A muldiv op in ID/EX stalls until DONE, where it retires.
    assign ex_stall = mem_stall || md_busy
                   || (md_op && !md_done && !rst);

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_mem_valid      <= 1'b0;
            ex_mem_alu_result <= '0;
            ex_mem_store_data <= '0;
            ex_mem_rd         <= '0;
            ex_mem_regwrite   <= 1'b0;
            ex_mem_memread    <= 1'b0;
            ex_mem_memwrite   <= 1'b0;
            ex_mem_memtoreg   <= 1'b0;
        end else if (!mem_stall) begin
            if (!id_ex_valid || (md_op && !md_done)) begin
                ex_mem_valid      <= 1'b0;
                ex_mem_alu_result <= '0;
                ex_mem_store_data <= '0;
                ex_mem_rd         <= '0;
                ex_mem_regwrite   <= 1'b0;
                ex_mem_memread    <= 1'b0;
                ex_mem_memwrite   <= 1'b0;
                ex_mem_memtoreg   <= 1'b0;
            end else begin
                // Retiring muldiv ops only update HI/LO.
                ex_mem_valid      <= 1'b1;
                ex_mem_alu_result <= alu_res;
                ex_mem_store_data <= opbf;
                ex_mem_rd         <= id_ex_dst;
                ex_mem_regwrite   <= id_ex_regwrite && !md_op;
                ex_mem_memread    <= id_ex_memread && !md_op;
                ex_mem_memwrite   <= id_ex_memwrite && !md_op;
                ex_mem_memtoreg   <= id_ex_memtoreg && !md_op;
            end
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: forwarding, ALU ops, stalls, muldiv
// timing and results, reset in the middle of a multiply.
module tb_ex_stage;
    import mips_pkg::*;

    logic        clk;
    logic        rst;
    logic        id_ex_valid;
    logic [31:0] id_ex_rs_data;
    logic [31:0] id_ex_rt_data;
    logic [31:0] id_ex_imm;
    logic [3:0]  id_ex_alu_op;
    logic        id_ex_alu_src;
    logic        id_ex_regwrite;
    logic        id_ex_memread;
    logic        id_ex_memwrite;
    logic        id_ex_memtoreg;
    logic [4:0]  id_ex_dst;
    logic [1:0]  forward_a;
    logic [1:0]  forward_b;
    logic [31:0] ex_mem_fwd_data;
    logic [31:0] mem_wb_fwd_data;
    logic        mem_stall;
    logic        ex_stall;
    logic        ex_mem_valid;
    logic [31:0] ex_mem_alu_result;
    logic [31:0] ex_mem_store_data;
    logic [4:0]  ex_mem_rd;
    logic        ex_mem_regwrite;
    logic        ex_mem_memread;
    logic        ex_mem_memwrite;
    logic        ex_mem_memtoreg;

    int total;
    int fails;

    ex_stage dut (
        .clk               (clk),
        .rst               (rst),
        .id_ex_valid       (id_ex_valid),
        .id_ex_rs_data     (id_ex_rs_data),
        .id_ex_rt_data     (id_ex_rt_data),
        .id_ex_imm         (id_ex_imm),
        .id_ex_alu_op      (id_ex_alu_op),
        .id_ex_alu_src     (id_ex_alu_src),
        .id_ex_regwrite    (id_ex_regwrite),
        .id_ex_memread     (id_ex_memread),
        .id_ex_memwrite    (id_ex_memwrite),
        .id_ex_memtoreg    (id_ex_memtoreg),
        .id_ex_dst         (id_ex_dst),
        .forward_a         (forward_a),
        .forward_b         (forward_b),
        .ex_mem_fwd_data   (ex_mem_fwd_data),
        .mem_wb_fwd_data   (mem_wb_fwd_data),
        .mem_stall         (mem_stall),
        .ex_stall          (ex_stall),
        .ex_mem_valid      (ex_mem_valid),
        .ex_mem_alu_result (ex_mem_alu_result),
        .ex_mem_store_data (ex_mem_store_data),
        .ex_mem_rd         (ex_mem_rd),
        .ex_mem_regwrite   (ex_mem_regwrite),
        .ex_mem_memread    (ex_mem_memread),
        .ex_mem_memwrite   (ex_mem_memwrite),
        .ex_mem_memtoreg   (ex_mem_memtoreg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] op, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [31:0] imm,
                         input logic src, input logic [1:0] fa,
                         input logic [1:0] fb, input logic rw,
                         input logic mw, input logic [4:0] dst);
        id_ex_valid    = 1'b1;
        id_ex_alu_op   = op;
        id_ex_rs_data  = rs;
        id_ex_rt_data  = rt;
        id_ex_imm      = imm;
        id_ex_alu_src  = src;
        forward_a      = fa;
        forward_b      = fb;
        id_ex_regwrite = rw;
        id_ex_memwrite = mw;
        id_ex_memread  = 1'b0;
        id_ex_memtoreg = 1'b0;
        id_ex_dst      = dst;
    endtask

    // Present a muldiv op, count stall cycles, then check retirement.
    task automatic run_md(input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input string tag);
        int cnt;
        drive(op, a, b, 32'd0, 1'b0, FWD_RF, FWD_RF, 1'b1, 1'b0, 5'd7);
        #1;
        cnt = 0;
        for (int i = 0; i < 100 && ex_stall; i++) begin
            cnt++;
            tick();
        end
        check({tag, "_stall_cycles"}, cnt, 32'd33);
        check({tag, "_done_bubble"}, ex_mem_valid, 1'b0);
        tick();
        check({tag, "_retire_valid"}, ex_mem_valid, 1'b1);
        check({tag, "_retire_rw"}, ex_mem_regwrite, 1'b0);
    endtask

    task automatic read_hilo(input logic [31:0] exp_hi,
                             input logic [31:0] exp_lo, input string tag);
        drive(OP_MFLO, 0, 0, 0, 1'b0, FWD_RF, FWD_RF, 1'b1, 1'b0, 5'd8);
        #1;
        check({tag, "_mflo_nostall"}, ex_stall, 1'b0);
        tick();
        check({tag, "_lo"}, ex_mem_alu_result, exp_lo);
        drive(OP_MFHI, 0, 0, 0, 1'b0, FWD_RF, FWD_RF, 1'b1, 1'b0, 5'd9);
        tick();
        check({tag, "_hi"}, ex_mem_alu_result, exp_hi);
    endtask

    initial begin
        total = 0;
        fails = 0;
        rst = 1'b1;
        mem_stall = 1'b0;
        ex_mem_fwd_data = '0;
        mem_wb_fwd_data = '0;
        drive(OP_ADD, 0, 0, 0, 1'b0, FWD_RF, FWD_RF, 1'b0, 1'b0, 5'd0);
        id_ex_valid = 1'b0;
        tick();
        tick();
        check("rst_valid", ex_mem_valid, 1'b0);
        check("rst_result", ex_mem_alu_result, 32'd0);
        check("rst_store", ex_mem_store_data, 32'd0);
        check("rst_rd", ex_mem_rd, 5'd0);
        check("rst_rw", ex_mem_regwrite, 1'b0);
        check("rst_stall_low", ex_stall, 1'b0);
        mem_stall = 1'b1;
        #1;
        check("rst_stall_follow", ex_stall, 1'b1);
        mem_stall = 1'b0;
        rst = 1'b0;
        tick();

        ex_mem_fwd_data = 32'd5;
        drive(OP_ADD, 32'd99, 32'd7, 0, 1'b0, FWD_EXMEM, FWD_RF,
              1'b1, 1'b0, 5'd3);
        tick();
        check("add_fwd", ex_mem_alu_result, 32'd12);
        check("add_rw", ex_mem_regwrite, 1'b1);
        check("add_valid", ex_mem_valid, 1'b1);
        check("add_rd", ex_mem_rd, 5'd3);

        drive(OP_SLT, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, FWD_RF, FWD_RF,
              1'b1, 1'b0, 5'd4);
        tick();
        check("slt", ex_mem_alu_result, 32'd1);
        drive(OP_SLTU, 32'hFFFF_FFFF, 32'd1, 0, 1'b0, FWD_RF, FWD_RF,
              1'b1, 1'b0, 5'd4);
        tick();
        check("sltu", ex_mem_alu_result, 32'd0);

        mem_wb_fwd_data = 32'h8000_0000;
        drive(OP_SRA, 0, 32'd5, 32'h0000_0100, 1'b0, FWD_RF, FWD_MEMWB,
              1'b1, 1'b0, 5'd5);
        tick();
        check("sra_fwd", ex_mem_alu_result, 32'hF800_0000);

        drive(OP_ADD, 32'h100, 32'hDEAD, 32'd8, 1'b1, FWD_RF, FWD_RF,
              1'b0, 1'b1, 5'd0);
        tick();
        check("sw_addr", ex_mem_alu_result, 32'h108);
        check("sw_data", ex_mem_store_data, 32'hDEAD);
        check("sw_mw", ex_mem_memwrite, 1'b1);
        check("sw_rw", ex_mem_regwrite, 1'b0);

        ex_mem_fwd_data = 32'd100;
        drive(OP_ADD, 32'd1, 32'd2, 0, 1'b0, 2'b11, 2'b11,
              1'b1, 1'b0, 5'd6);
        tick();
        check("fwd11_rf", ex_mem_alu_result, 32'd3);

        drive(OP_LUI, 0, 0, 32'h0000_1234, 1'b1, FWD_RF, FWD_RF,
              1'b1, 1'b0, 5'd6);
        tick();
        check("lui", ex_mem_alu_result, 32'h1234_0000);

        drive(OP_ADD, 32'd20, 32'd22, 0, 1'b0, FWD_RF, FWD_RF,
              1'b1, 1'b0, 5'd10);
        mem_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("mstall_stall", ex_stall, 1'b1);
            tick();
            check("mstall_hold", ex_mem_alu_result, 32'h1234_0000);
        end
        mem_stall = 1'b0;
        tick();
        check("mstall_release", ex_mem_alu_result, 32'd42);
        check("mstall_rd", ex_mem_rd, 5'd10);

        id_ex_valid = 1'b0;
        tick();
        check("bubble_valid", ex_mem_valid, 1'b0);
        check("bubble_rw", ex_mem_regwrite, 1'b0);

        run_md(OP_MULT, 32'hFFFF_FFFD, 32'd7, "mult");
        read_hilo(32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult");

        run_md(OP_DIVU, 32'd100, 32'd7, "divu");
        read_hilo(32'd2, 32'd14, "divu");

        run_md(OP_DIVU, 32'd9, 32'd0, "div0");
        read_hilo(32'd9, 32'hFFFF_FFFF, "div0");

        drive(OP_MULT, 32'd5, 32'd6, 0, 1'b0, FWD_RF, FWD_RF,
              1'b1, 1'b0, 5'd7);
        repeat (22) tick();
        check("midrst_busy", ex_stall, 1'b1);
        rst = 1'b1;
        id_ex_valid = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        check("midrst_stall", ex_stall, 1'b0);
        check("midrst_valid", ex_mem_valid, 1'b0);
        check("midrst_result", ex_mem_alu_result, 32'd0);
        check("midrst_store", ex_mem_store_data, 32'd0);
        check("midrst_rd", ex_mem_rd, 5'd0);
        read_hilo(32'd0, 32'd0, "midrst");

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

endmodule
